// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: FunSel codes, FSM state
// encoding and ZCNO flag bit positions.
package alu_seq_pkg;

   localparam logic [3:0] OP_PASS_A = 4'b0000;
   localparam logic [3:0] OP_PASS_B = 4'b0001;
   localparam logic [3:0] OP_NOT_A  = 4'b0010;
   localparam logic [3:0] OP_NOT_B  = 4'b0011;
   localparam logic [3:0] OP_ADD    = 4'b0100;
   localparam logic [3:0] OP_SUB    = 4'b0101;
   localparam logic [3:0] OP_CMP    = 4'b0110;
   localparam logic [3:0] OP_AND    = 4'b0111;
   localparam logic [3:0] OP_OR     = 4'b1000;
   localparam logic [3:0] OP_NAND   = 4'b1001;
   localparam logic [3:0] OP_XOR    = 4'b1010;
   localparam logic [3:0] OP_LSL    = 4'b1011;
   localparam logic [3:0] OP_LSR    = 4'b1100;
   localparam logic [3:0] OP_ASR    = 4'b1101;
   localparam logic [3:0] OP_CSL    = 4'b1110;
   localparam logic [3:0] OP_CSR    = 4'b1111;

   localparam int ZCNO_Z = 3;
   localparam int ZCNO_C = 2;
   localparam int ZCNO_N = 1;
   localparam int ZCNO_O = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   // Compare only updates flags; every other op writes its result back.
   function automatic logic op_writes_rf(input logic [3:0] op);
      return op != OP_CMP;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/completion bundle between a requester and the ALU op sequencer.
// ALU_SEQ_IMM_EN adds the immediate-operand request fields.
interface alu_op_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int AW     = 2
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [AW-1:0]     req_src_a;
   logic [AW-1:0]     req_src_b;
   logic [AW-1:0]     req_dst;
`ifdef ALU_SEQ_IMM_EN
   logic              req_use_imm;
   logic [DATA_W-1:0] req_imm;
`endif
   logic              done_valid;
   logic [DATA_W-1:0] done_result;
   logic [3:0]        done_flags;

`ifdef ALU_SEQ_IMM_EN
   modport master (
      output req_valid, req_op, req_src_a, req_src_b, req_dst, req_use_imm, req_imm,
      input  req_ready, done_valid, done_result, done_flags
   );
   modport slave (
      input  req_valid, req_op, req_src_a, req_src_b, req_dst, req_use_imm, req_imm,
      output req_ready, done_valid, done_result, done_flags
   );
`else
   modport master (
      output req_valid, req_op, req_src_a, req_src_b, req_dst,
      input  req_ready, done_valid, done_result, done_flags
   );
   modport slave (
      input  req_valid, req_op, req_src_a, req_src_b, req_dst,
      output req_ready, done_valid, done_result, done_flags
   );
`endif
endinterface

// File: rtl/alu_seq_regfile.sv
// Operand register file: async clear, two operand ports latched on request
// acceptance, combinational debug read, write-back has priority over load.
module alu_seq_regfile #(
   parameter int DATA_W = 8,
   parameter int AW     = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              wb_en_i,
   input  logic [AW-1:0]     wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              ld_en_i,
   input  logic [AW-1:0]     ld_addr_i,
   input  logic [DATA_W-1:0] ld_data_i,
   input  logic              lat_en_i,
   input  logic [AW-1:0]     lat_addr_a_i,
   input  logic [AW-1:0]     lat_addr_b_i,
   output logic [DATA_W-1:0] lat_a_o,
   output logic [DATA_W-1:0] lat_b_o,
   input  logic [AW-1:0]     dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
);
   localparam int NREG = 1 << AW;

   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] lat_a_q;
   logic [DATA_W-1:0] lat_b_q;

   // Write-back is applied last so it overrides a same-index load.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         if (ld_en_i) rf_q[ld_addr_i] <= ld_data_i;
         if (wb_en_i) rf_q[wb_addr_i] <= wb_data_i;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lat_a_q <= '0;
         lat_b_q <= '0;
      end else if (lat_en_i) begin
         lat_a_q <= rf_q[lat_addr_a_i];
         lat_b_q <= rf_q[lat_addr_b_i];
      end
   end

   assign lat_a_o    = lat_a_q;
   assign lat_b_o    = lat_b_q;
   assign dbg_data_o = rf_q[dbg_addr_i];
endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/write-back stage around a clocked FunSel ALU (one op per 4 cycles).
// Optional macro ALU_SEQ_IMM_EN: B operand may come from the request immediate.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int AW     = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   alu_op_sequencer_if.slave bus,
   input  logic              ld_en,
   input  logic [AW-1:0]     ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_funsel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [3:0]        alu_zcno,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   seq_state_e        state_q, state_d;
   logic [3:0]        op_q;
   logic [AW-1:0]     dst_q;
   logic [DATA_W-1:0] rf_a_q;
   logic [DATA_W-1:0] rf_b_q;
   logic [DATA_W-1:0] opnd_b;
   logic [DATA_W-1:0] done_result_q;
   logic [3:0]        done_flags_q;
   logic              accept;
   logic              capture;
   logic              wb_en;

   assign accept  = (state_q == ST_IDLE) && bus.req_valid;
   assign capture = (state_q == ST_WAIT);
   assign wb_en   = capture && op_writes_rf(op_q);

   alu_seq_regfile #(.DATA_W(DATA_W), .AW(AW)) u_rf (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .wb_en_i      (wb_en),
      .wb_addr_i    (dst_q),
      .wb_data_i    (alu_out),
      .ld_en_i      (ld_en),
      .ld_addr_i    (ld_addr),
      .ld_data_i    (ld_data),
      .lat_en_i     (accept),
      .lat_addr_a_i (bus.req_src_a),
      .lat_addr_b_i (bus.req_src_b),
      .lat_a_o      (rf_a_q),
      .lat_b_o      (rf_b_q),
      .dbg_addr_i   (rd_addr),
      .dbg_data_o   (rd_data)
   );

`ifdef ALU_SEQ_IMM_EN
   logic              use_imm_q;
   logic [DATA_W-1:0] imm_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         use_imm_q <= 1'b0;
         imm_q     <= '0;
      end else if (accept) begin
         use_imm_q <= bus.req_use_imm;
         imm_q     <= bus.req_imm;
      end
   end

   assign opnd_b = use_imm_q ? imm_q : rf_b_q;
`else
   assign opnd_b = rf_b_q;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.req_valid) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Idle cycles issue pass-A of zero so the ALU carry/overflow survive between ops.
   always_comb begin
      bus.req_ready  = 1'b0;
      bus.done_valid = 1'b0;
      alu_a          = '0;
      alu_b          = '0;
      alu_funsel     = OP_PASS_A;
      case (state_q)
         ST_IDLE: bus.req_ready = 1'b1;
         ST_ISSUE, ST_WAIT: begin
            alu_a      = rf_a_q;
            alu_b      = opnd_b;
            alu_funsel = op_q;
         end
         ST_DONE: bus.done_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_q  <= OP_PASS_A;
         dst_q <= '0;
      end else if (accept) begin
         op_q  <= bus.req_op;
         dst_q <= bus.req_dst;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         done_result_q <= '0;
         done_flags_q  <= '0;
      end else if (capture) begin
         done_result_q <= alu_out;
         done_flags_q  <= alu_zcno;
      end
   end

   assign bus.done_result = done_result_q;
   assign bus.done_flags  = done_flags_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural clocked FunSel ALU.
// Build with ALU_SEQ_IMM_EN to also exercise the immediate B operand.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   logic       CLK;
   logic       RST_N;
   logic       ld_en;
   logic [1:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [3:0] alu_funsel, alu_zcno;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;

   int checks   = 0;
   int failures = 0;

   logic [7:0] got_res;
   logic [3:0] got_flags;

   alu_op_sequencer_if #(.DATA_W(8), .AW(2)) bus ();

   alu_op_sequencer #(.DATA_W(8), .AW(2)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .bus        (bus),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_funsel (alu_funsel),
      .alu_out    (alu_out),
      .alu_zcno   (alu_zcno),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural clocked ALU: registered OutALU and ZCNO, carry not reset.
   logic [7:0] m_out_q  = '0;
   logic [3:0] m_zcno_q = '0;
   logic [7:0] m_out_d, m_flag_v;
   logic [3:0] m_zcno_d;
   logic [8:0] m_sum;
   logic       m_is_sub;

   always_comb begin
      m_out_d  = alu_a;
      m_zcno_d = m_zcno_q;
      m_sum    = '0;
      m_flag_v = '0;
      m_is_sub = 1'b0;
      case (alu_funsel)
         OP_ADD: begin
            m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, m_zcno_q[ZCNO_C]};
            m_out_d = m_sum[7:0];
            m_zcno_d[ZCNO_C] = m_sum[8];
            m_zcno_d[ZCNO_O] = (alu_a[7] == alu_b[7]) && (m_sum[7] != alu_a[7]);
         end
         OP_SUB, OP_CMP: begin
            m_is_sub = 1'b1;
            m_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            m_out_d = (alu_funsel == OP_CMP) ? alu_a : m_sum[7:0];
            m_zcno_d[ZCNO_C] = m_sum[8];
            m_zcno_d[ZCNO_O] = (alu_a[7] != alu_b[7]) && (m_sum[7] != alu_a[7]);
         end
         OP_AND:  m_out_d = alu_a & alu_b;
         OP_XOR:  m_out_d = alu_a ^ alu_b;
         default: m_out_d = alu_a;
      endcase
      m_flag_v = m_is_sub ? m_sum[7:0] : m_out_d;
      m_zcno_d[ZCNO_Z] = (m_flag_v == 8'h00);
      m_zcno_d[ZCNO_N] = m_flag_v[7];
   end

   always @(posedge CLK) begin
      m_out_q  <= m_out_d;
      m_zcno_q <= m_zcno_d;
   end

   assign alu_out  = m_out_q;
   assign alu_zcno = m_zcno_q;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      check_eq(tag, rd_data, exp);
   endtask

   task automatic load_reg(input logic [1:0] a, input logic [7:0] d);
      @(negedge CLK);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge CLK);
      ld_en = 1'b0;
   endtask

   task automatic set_req(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] dst, input logic use_imm, input logic [7:0] imm);
      bus.req_op = op; bus.req_src_a = sa; bus.req_src_b = sb; bus.req_dst = dst;
`ifdef ALU_SEQ_IMM_EN
      bus.req_use_imm = use_imm;
      bus.req_imm     = imm;
`else
      if (use_imm || imm != 8'h00) $display("note: immediate ignored in this build");
`endif
   endtask

   // Issue one request and wait for its completion pulse.
   task automatic do_op(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] dst, input logic use_imm, input logic [7:0] imm);
      int lat;
      @(negedge CLK);
      check_eq("ready_idle", bus.req_ready, 1);
      set_req(op, sa, sb, dst, use_imm, imm);
      bus.req_valid = 1'b1;
      @(negedge CLK);
      bus.req_valid = 1'b0;
      check_eq("issue_funsel", alu_funsel, op);
      lat = 0;
      while (!bus.done_valid && lat < 10) begin
         @(negedge CLK);
         lat++;
      end
      check_eq("latency", lat, 2);
      check_eq("done_funsel_passa", alu_funsel, OP_PASS_A);
      got_res   = bus.done_result;
      got_flags = bus.done_flags;
      @(negedge CLK);
      check_eq("done_one_cycle", bus.done_valid, 0);
   endtask

   initial begin
      int low;
      int pulses;
      logic [7:0] r1, r2;

      RST_N = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
      bus.req_valid = 1'b0;
      set_req(OP_PASS_A, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check_eq("rst_ready", bus.req_ready, 1);
      check_eq("rst_done_valid", bus.done_valid, 0);
      check_eq("rst_done_result", bus.done_result, 0);
      check_eq("rst_done_flags", bus.done_flags, 0);
      check_eq("rst_alu_a", alu_a, 0);
      check_eq("rst_alu_b", alu_b, 0);
      check_eq("rst_funsel", alu_funsel, 0);
      for (int i = 0; i < 4; i++) check_reg("rst_rf", 2'(i), 8'h00);

      // ADD 70+10 -> 80, overflow into sign
      load_reg(2'd0, 8'h70);
      load_reg(2'd1, 8'h10);
      do_op(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
      check_eq("add_result", got_res, 8'h80);
      check_eq("add_flags", got_flags, 4'b0011);
      check_reg("add_r2", 2'd2, 8'h80);

      // Carry out then carry-in preserved across idle cycles
      load_reg(2'd0, 8'hFF);
      load_reg(2'd1, 8'h01);
      do_op(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
      check_eq("carry_result", got_res, 8'h00);
      check_eq("carry_flags", got_flags, 4'b1100);
      repeat (4) @(negedge CLK);
      do_op(OP_ADD, 2'd1, 2'd1, 2'd3, 1'b0, 8'h00);
      check_eq("carry_in_result", got_res, 8'h03);
      check_eq("carry_in_flags", got_flags, 4'b0000);
      check_reg("carry_in_r3", 2'd3, 8'h03);

      // Compare never writes back
      load_reg(2'd0, 8'h05);
      load_reg(2'd1, 8'h03);
      load_reg(2'd3, 8'hAA);
      do_op(OP_CMP, 2'd0, 2'd1, 2'd3, 1'b0, 8'h00);
      check_eq("cmp_result", got_res, 8'h05);
      check_reg("cmp_r3_kept", 2'd3, 8'hAA);

      // Back-to-back requests with req_valid held high
      @(negedge CLK);
      check_eq("hs_ready", bus.req_ready, 1);
      set_req(OP_XOR, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
      bus.req_valid = 1'b1;
      @(negedge CLK);
      set_req(OP_XOR, 2'd1, 2'd1, 2'd3, 1'b0, 8'h00);
      low = 0; r1 = 8'h5A;
      while (!bus.req_ready && low < 10) begin
         if (bus.done_valid) r1 = bus.done_result;
         low++;
         @(negedge CLK);
      end
      check_eq("hs_busy1", low, 3);
      check_eq("hs_result1", r1, 8'h06);
      @(negedge CLK);
      bus.req_valid = 1'b0;
      low = 0; r2 = 8'h5A;
      while (!bus.req_ready && low < 10) begin
         if (bus.done_valid) r2 = bus.done_result;
         low++;
         @(negedge CLK);
      end
      check_eq("hs_busy2", low, 3);
      check_eq("hs_result2", r2, 8'h00);
      check_reg("hs_r2", 2'd2, 8'h06);
      check_reg("hs_r3", 2'd3, 8'h00);

`ifdef ALU_SEQ_IMM_EN
      // Immediate B operand replaces rf[src_b]
      load_reg(2'd0, 8'h0F);
      do_op(OP_SUB, 2'd0, 2'd2, 2'd1, 1'b1, 8'h10);
      check_eq("imm_result", got_res, 8'hFF);
      check_eq("imm_flag_n", got_flags[ZCNO_N], 1);
      check_reg("imm_r1", 2'd1, 8'hFF);
`endif

      // Load at acceptance reads old value; load at write-back loses
      load_reg(2'd0, 8'h02);
      load_reg(2'd1, 8'h03);
      @(negedge CLK);
      set_req(OP_XOR, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
      bus.req_valid = 1'b1;
      ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h50;
      @(negedge CLK);
      bus.req_valid = 1'b0;
      ld_en = 1'b0;
      @(negedge CLK);
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h77;
      @(negedge CLK);
      ld_en = 1'b0;
      check_eq("coll_done_valid", bus.done_valid, 1);
      check_eq("coll_result", bus.done_result, 8'h01);
      check_reg("coll_r0_loaded", 2'd0, 8'h50);
      check_reg("coll_r2_wb_wins", 2'd2, 8'h01);

      // Reset during WAIT abandons the op
      @(negedge CLK);
      set_req(OP_ADD, 2'd0, 2'd1, 2'd3, 1'b0, 8'h00);
      bus.req_valid = 1'b1;
      @(negedge CLK);
      bus.req_valid = 1'b0;
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      check_eq("mid_rst_done_valid", bus.done_valid, 0);
      check_eq("mid_rst_flags", bus.done_flags, 0);
      check_eq("mid_rst_result", bus.done_result, 0);
      for (int i = 0; i < 4; i++) check_reg("mid_rst_rf", 2'(i), 8'h00);
      pulses = 0;
      repeat (2) begin
         @(negedge CLK);
         if (bus.done_valid) pulses++;
      end
      RST_N = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         if (bus.done_valid) pulses++;
      end
      check_eq("mid_rst_no_done", pulses, 0);
      check_eq("mid_rst_ready", bus.req_ready, 1);
      check_reg("mid_rst_r3", 2'd3, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/write-back stage wrapped around the clocked 8-bit ALU (FunSel-encoded, registered OutALU and ZCNO flags).
- Holds a 4x8 operand register file and accepts one operation request through a valid/ready handshake.
- Drives the ALU's A, B and FunSel, captures its result and flags, writes the result back, and reports completion.
- It is both the direct upstream feeder and the downstream consumer of the ALU.

Parameters:
- DATA_W, 8, operand/result width; fixed to the ALU width.
- AW, 2, register-file address width (2^AW registers).

Ports:
- CLK  in  1  clock; the ALU shares this clock.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  4  ALU FunSel code.
- req_src_a  in  AW  register index for A.
- req_src_b  in  AW  register index for B.
- req_dst  in  AW  destination register index.
- ld_en  in  1  direct register load.
- ld_addr  in  AW  load index.
- ld_data  in  DATA_W  load value.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_funsel  out  4  to ALU FunSel.
- alu_out  in  DATA_W  from ALU OutALU.
- alu_zcno  in  4  from ALU ZCNO (Z,C,N,O = bits 3..0).
- done_valid  out  1  one-cycle completion pulse.
- done_result  out  DATA_W  captured ALU result.
- done_flags  out  4  captured ZCNO.
- rd_addr  in  AW  debug read index.
- rd_data  out  DATA_W  combinational rf[rd_addr].

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE and all rf entries are cleared to 0.
  - done_valid=0, done_result=0, done_flags=0, alu_a=0, alu_b=0, alu_funsel=4'b0000, req_ready=1 once RST_N is released.
  - Reset mid-operation abandons the op with no write-back.
  - The ALU's internal carry is not reset by this block.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - req_ready=1; req_ready is 0 in every other state.
  - The handshake completes at edge E0 when req_valid && req_ready.
  - At E0 the sequencer latches op, dst, rf[src_a] and rf[src_b], using pre-edge rf contents.
- ISSUE (E0..E1):
  - alu_a/alu_b/alu_funsel are driven from the latched values.
  - The ALU samples them at E1.
- WAIT (E1..E2): inputs are held; the ALU result and flags settle within the cycle.
- At E2:
  - done_result<=alu_out and done_flags<=alu_zcno.
  - If op!=4'b0110 (compare), rf[dst]<=alu_out; a compare never writes the rf.
  - State moves to DONE.
- DONE (E2..E3): done_valid=1 for exactly one cycle, then IDLE.
- Latency and throughput: result is visible 2 cycles after acceptance; one op per 4 cycles.
- Outside ISSUE/WAIT:
  - alu_funsel=4'b0000 (pass A) with alu_a=alu_b=0.
  - Pass A leaves the ALU's C and O untouched, so the carry chain for ADD carry-in and CSR survives between ops.
  - Only done_flags is architectural.
- ld_en is honoured in any state; it writes rf[ld_addr]<=ld_data.
- ld_en in the same edge as acceptance: the request reads the old value (no forwarding).
- ld_en in the same edge as write-back to the same index: write-back wins.
- done_result/done_flags hold their values until the next E2.

Optional Feature:
- Macro: ALU_SEQ_IMM_EN.
- When defined:
  - Adds ports req_use_imm (in, 1) and req_imm (in, DATA_W).
  - If req_use_imm=1 at acceptance, the B operand is req_imm instead of rf[req_src_b].
- When undefined: those ports do not exist and B always comes from the rf.

Decomposition:
- Shared package alu_seq_pkg:
  - FunSel localparams (OP_PASS_A=0000 through OP_CSR=1111, OP_CMP=0110).
  - State encoding for IDLE/ISSUE/WAIT/DONE.
  - ZCNO bit indices.
- One sub-module, alu_seq_regfile:
  - 2^AW x DATA_W.
  - Async clear, two latched read ports, one combinational debug read, prioritised write (write-back over ld).
- The bench instantiates the existing ALU alongside the sequencer.

Test Plan:
- Load R0=8'h70, R1=8'h10; ADD (0100) R0,R1->R2 -> done_valid two cycles after accept, done_result=8'h80, done_flags=4'b0011, R2=8'h80.
- Carry chain: R0=8'hFF, R1=8'h01, ADD ->R2 gives 8'h00 with flags 4'b1100; after idle cycles, ADD R1,R1->R3 gives 8'h03 (carry-in preserved by pass-A idling).
- Compare: R0=8'h05, R1=8'h03, R3=8'hAA; CMP (0110) dst R3 -> done_result=8'h05, R3 stays 8'hAA.
- Handshake: hold req_valid high for two back-to-back requests -> second accepted only after DONE returns to IDLE; req_ready low for 3 cycles after each accept.
- Reset mid-op: assert RST_N=0 during WAIT -> immediate IDLE, no done_valid, all rd_data=0, done_flags=0.
- With ALU_SEQ_IMM_EN: R0=8'h0F, SUB (0101) with req_imm=8'h10 ->R1 gives 8'hFF, N=1.
